// File: rtl/z80_clk_ctrl.sv
// CPU clock and reset controller for the Z80 core: loadable divider with
// run/halt/single-step modes, phase strobes, stretched CPU reset and cycle counter.
module z80_clk_ctrl #(
  parameter int DIV_WIDTH    = 16,
  parameter int DEFAULT_HALF = 10000,
  parameter int RESET_CYCLES = 8,
  parameter int CYC_WIDTH    = 16
) (
  input  logic                 mclk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] half_period,
  input  logic                 load,
  input  logic [1:0]           mode,
  input  logic                 step,
  input  logic                 cpu_rst_req,
  output logic                 cpu_clk,
  output logic                 cpu_clk_rise,
  output logic                 cpu_clk_fall,
  output logic                 cpu_nreset,
  output logic                 running,
  output logic [CYC_WIDTH-1:0] cycle_cnt
);

  localparam int RST_WIDTH = $clog2(RESET_CYCLES + 1);
  localparam logic [RST_WIDTH-1:0] RST_LOAD  = RST_WIDTH'(RESET_CYCLES);
  localparam logic [DIV_WIDTH-1:0] HALF_INIT = DIV_WIDTH'(DEFAULT_HALF);

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_HALT    = 2'b01,
    MODE_STEP    = 2'b10,
    MODE_RUN_ALT = 2'b11
  } mode_e;

  mode_e                 mode_sel;
  logic [DIV_WIDTH-1:0]  count;
  logic [DIV_WIDTH-1:0]  active_half;
  logic [RST_WIDTH-1:0]  rst_cnt;
  logic                  step_prev;
  logic                  step_busy;
  logic                  advance;
  logic                  toggle;
  logic                  step_start;
  logic                  fall_evt;
  logic                  rise_evt;

  // A pending reset stretch or an unfinished high phase keeps the divider
  // moving regardless of mode.
  always_comb begin
    mode_sel   = mode_e'(mode);
    advance    = (rst_cnt != '0) || (mode_sel == MODE_RUN) ||
                 (mode_sel == MODE_RUN_ALT) || step_busy || cpu_clk;
    toggle     = advance && (count >= active_half);
    rise_evt   = toggle && !cpu_clk;
    fall_evt   = toggle && cpu_clk;
    step_start = (mode_sel == MODE_STEP) && step && !step_prev &&
                 !step_busy && !cpu_clk;
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      count        <= '0;
      active_half  <= HALF_INIT;
      cpu_clk      <= 1'b0;
      cpu_clk_rise <= 1'b0;
      cpu_clk_fall <= 1'b0;
      running      <= 1'b0;
    end else begin
      cpu_clk_rise <= 1'b0;
      cpu_clk_fall <= 1'b0;
      running      <= advance;
      if (load) active_half <= half_period;
      // Parking clears the count so a resumed clock starts a fresh phase.
      if (!advance) begin
        count <= '0;
      end else if (toggle) begin
        count        <= '0;
        cpu_clk      <= ~cpu_clk;
        cpu_clk_rise <= rise_evt;
        cpu_clk_fall <= fall_evt;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  // A step covers the idle low half plus the high half; it retires on the
  // falling toggle so the divider parks with count already at zero.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      step_prev <= 1'b0;
      step_busy <= 1'b0;
    end else begin
      step_prev <= step;
      if (step_start) step_busy <= 1'b1;
      else if (fall_evt) step_busy <= 1'b0;
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      rst_cnt    <= RST_LOAD;
      cpu_nreset <= 1'b0;
      cycle_cnt  <= '0;
    end else begin
      cpu_nreset <= (rst_cnt == '0);
      if (cpu_rst_req) rst_cnt <= RST_LOAD;
      else if (fall_evt && (rst_cnt != '0)) rst_cnt <= rst_cnt - 1'b1;
      if (cpu_rst_req) cycle_cnt <= '0;
      else if (rise_evt) cycle_cnt <= cycle_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_z80_clk_ctrl.sv
// Self-checking bench for z80_clk_ctrl: expected waveforms come from phase
// arithmetic (edge index divided by half-period length) re-aligned at known idle points.
module tb_z80_clk_ctrl;
  localparam int DIV_WIDTH    = 16;
  localparam int DEFAULT_HALF = 3;
  localparam int RESET_CYCLES = 2;
  localparam int CYC_WIDTH    = 4;

  logic                 mclk = 1'b0;
  logic                 reset;
  logic [DIV_WIDTH-1:0] half_period;
  logic                 load;
  logic [1:0]           mode;
  logic                 step;
  logic                 cpu_rst_req;
  logic                 cpu_clk;
  logic                 cpu_clk_rise;
  logic                 cpu_clk_fall;
  logic                 cpu_nreset;
  logic                 running;
  logic [CYC_WIDTH-1:0] cycle_cnt;

  int tests_run    = 0;
  int tests_failed = 0;
  int cur_half     = DEFAULT_HALF;
  int exp_cyc      = 0;

  always #5 mclk = ~mclk;

  z80_clk_ctrl #(
    .DIV_WIDTH(DIV_WIDTH), .DEFAULT_HALF(DEFAULT_HALF),
    .RESET_CYCLES(RESET_CYCLES), .CYC_WIDTH(CYC_WIDTH)
  ) dut (
    .mclk(mclk), .reset(reset), .half_period(half_period), .load(load),
    .mode(mode), .step(step), .cpu_rst_req(cpu_rst_req), .cpu_clk(cpu_clk),
    .cpu_clk_rise(cpu_clk_rise), .cpu_clk_fall(cpu_clk_fall),
    .cpu_nreset(cpu_nreset), .running(running), .cycle_cnt(cycle_cnt)
  );

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  // cpu_clk after edge k of a run started from a parked divider: it flips
  // every (h+1) edges, beginning low.
  function automatic bit phase_high(int k, int h);
    return ((k / (h + 1)) % 2) == 1;
  endfunction

  task automatic load_half(int h);
    half_period = DIV_WIDTH'(h);
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    cur_half = h;
  endtask

  task automatic test_reset();
    reset = 1'b1; half_period = '0; load = 1'b0; mode = 2'b00;
    step = 1'b0; cpu_rst_req = 1'b0;
    repeat (3) tick();
    tests_run += 5;
    if (cpu_clk !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_clk got %b want 0", cpu_clk); end
    if (cpu_clk_rise !== 1'b0 || cpu_clk_fall !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_strobes got %b%b want 00", cpu_clk_rise, cpu_clk_fall); end
    if (cpu_nreset !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_nreset got %b want 0", cpu_nreset); end
    if (running !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_running got %b want 0", running); end
    if (cycle_cnt !== '0) begin tests_failed++; $display("[TB] FAIL reset_cycle got %0d want 0", cycle_cnt); end
    @(negedge mclk);
    reset = 1'b0;
  endtask

  task automatic test_startup();
    bit exp_clk, prev_clk;
    prev_clk = 1'b0;
    exp_cyc  = 0;
    for (int k = 1; k <= 22; k++) begin
      tick();
      exp_clk = phase_high(k, DEFAULT_HALF);
      if (exp_clk && !prev_clk) exp_cyc++;
      tests_run += 6;
      if (cpu_clk !== exp_clk) begin tests_failed++; $display("[TB] FAIL start_clk k=%0d got %b want %b", k, cpu_clk, exp_clk); end
      if (cpu_clk_rise !== (exp_clk && !prev_clk)) begin tests_failed++; $display("[TB] FAIL start_rise k=%0d got %b want %b", k, cpu_clk_rise, exp_clk && !prev_clk); end
      if (cpu_clk_fall !== (!exp_clk && prev_clk)) begin tests_failed++; $display("[TB] FAIL start_fall k=%0d got %b want %b", k, cpu_clk_fall, !exp_clk && prev_clk); end
      if (cpu_nreset !== (k >= 2 * RESET_CYCLES * (DEFAULT_HALF + 1) + 1)) begin tests_failed++; $display("[TB] FAIL start_nreset k=%0d got %b", k, cpu_nreset); end
      if (running !== 1'b1) begin tests_failed++; $display("[TB] FAIL start_running k=%0d got %b want 1", k, running); end
      if (cycle_cnt !== CYC_WIDTH'(exp_cyc)) begin tests_failed++; $display("[TB] FAIL start_cycle k=%0d got %0d want %0d", k, cycle_cnt, CYC_WIDTH'(exp_cyc)); end
      prev_clk = exp_clk;
    end
  endtask

  // Continues from edge 22 of the startup run, which is mid high phase.
  task automatic test_halt();
    bit exp_clk, prev_clk;
    prev_clk = 1'b1;
    mode = 2'b01;
    for (int k = 23; k <= 130; k++) begin
      tick();
      exp_clk = (k <= 24) ? phase_high(k, DEFAULT_HALF) : 1'b0;
      tests_run += 3;
      if (cpu_clk !== exp_clk) begin tests_failed++; $display("[TB] FAIL halt_clk k=%0d got %b want %b", k, cpu_clk, exp_clk); end
      if (cpu_clk_fall !== (!exp_clk && prev_clk)) begin tests_failed++; $display("[TB] FAIL halt_fall k=%0d got %b want %b", k, cpu_clk_fall, !exp_clk && prev_clk); end
      if (cycle_cnt !== CYC_WIDTH'(exp_cyc)) begin tests_failed++; $display("[TB] FAIL halt_cycle k=%0d got %0d want %0d", k, cycle_cnt, CYC_WIDTH'(exp_cyc)); end
      if (k >= 25) begin
        tests_run++;
        if (running !== 1'b0) begin tests_failed++; $display("[TB] FAIL halt_running k=%0d got %b want 0", k, running); end
      end
      prev_clk = exp_clk;
    end
  endtask

  task automatic test_load_midphase();
    bit exp_clk, prev_clk;
    prev_clk = 1'b0;
    mode = 2'b00;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k <= 6) exp_clk = phase_high(k, DEFAULT_HALF);
      else if (k <= 20) exp_clk = ((k - 7) % 2) == 1;
      else exp_clk = 1'b0;
      if (exp_clk && !prev_clk) exp_cyc++;
      tests_run += 2;
      if (cpu_clk !== exp_clk) begin tests_failed++; $display("[TB] FAIL load_clk k=%0d got %b want %b", k, cpu_clk, exp_clk); end
      if (cycle_cnt !== CYC_WIDTH'(exp_cyc)) begin tests_failed++; $display("[TB] FAIL load_cycle k=%0d got %0d want %0d", k, cycle_cnt, CYC_WIDTH'(exp_cyc)); end
      prev_clk = exp_clk;
      if (k == 5) begin half_period = '0; load = 1'b1; end
      if (k == 6) load = 1'b0;
      if (k == 20) mode = 2'b01;
    end
    cur_half = 0;
  endtask

  task automatic test_random_run();
    int h, len, q, stop_k;
    bit exp_clk, prev_clk;
    for (int it = 0; it < 8; it++) begin
      h = $urandom_range(0, 6);
      load_half(h);
      mode = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
      len = $urandom_range(1, 25);
      q = len / (h + 1);
      stop_k = (q % 2 == 1) ? (q + 1) * (h + 1) : len;
      prev_clk = 1'b0;
      for (int k = 1; k <= stop_k + 3; k++) begin
        tick();
        exp_clk = (k <= stop_k) ? phase_high(k, h) : 1'b0;
        if (exp_clk && !prev_clk) exp_cyc++;
        tests_run += 4;
        if (cpu_clk !== exp_clk) begin tests_failed++; $display("[TB] FAIL rand_clk it=%0d h=%0d k=%0d got %b want %b", it, h, k, cpu_clk, exp_clk); end
        if (cpu_clk_rise !== (exp_clk && !prev_clk)) begin tests_failed++; $display("[TB] FAIL rand_rise it=%0d k=%0d got %b", it, k, cpu_clk_rise); end
        if (cpu_clk_fall !== (!exp_clk && prev_clk)) begin tests_failed++; $display("[TB] FAIL rand_fall it=%0d k=%0d got %b", it, k, cpu_clk_fall); end
        if (cycle_cnt !== CYC_WIDTH'(exp_cyc)) begin tests_failed++; $display("[TB] FAIL rand_cycle it=%0d k=%0d got %0d want %0d", it, k, cycle_cnt, CYC_WIDTH'(exp_cyc)); end
        prev_clk = exp_clk;
        if (k == len) mode = 2'b01;
      end
      tests_run++;
      if (running !== 1'b0) begin tests_failed++; $display("[TB] FAIL rand_running it=%0d got %b want 0", it, running); end
    end
  endtask

  task automatic test_step();
    int h, s2;
    bit exp_clk, prev_clk;
    mode = 2'b10;
    for (int it = 0; it < 5; it++) begin
      h = $urandom_range(0, 5);
      load_half(h);
      s2 = $urandom_range(3, 2 * h + 3);
      prev_clk = 1'b0;
      step = 1'b1;
      for (int k = 1; k <= 2 * h + 8; k++) begin
        tick();
        step = (k + 1 == s2);
        exp_clk = (k >= h + 2) && (k <= 2 * h + 2);
        if (exp_clk && !prev_clk) exp_cyc++;
        tests_run += 4;
        if (cpu_clk !== exp_clk) begin tests_failed++; $display("[TB] FAIL step_clk h=%0d s2=%0d k=%0d got %b want %b", h, s2, k, cpu_clk, exp_clk); end
        if (cpu_clk_rise !== (exp_clk && !prev_clk)) begin tests_failed++; $display("[TB] FAIL step_rise k=%0d got %b", k, cpu_clk_rise); end
        if (cpu_clk_fall !== (!exp_clk && prev_clk)) begin tests_failed++; $display("[TB] FAIL step_fall k=%0d got %b", k, cpu_clk_fall); end
        if (cycle_cnt !== CYC_WIDTH'(exp_cyc)) begin tests_failed++; $display("[TB] FAIL step_cycle k=%0d got %0d want %0d", k, cycle_cnt, CYC_WIDTH'(exp_cyc)); end
        if (k == h + 2 || k == 2 * h + 8) begin
          tests_run++;
          if (running !== (k == h + 2)) begin tests_failed++; $display("[TB] FAIL step_running k=%0d got %b want %b", k, running, k == h + 2); end
        end
        prev_clk = exp_clk;
      end
    end
    // A step edge outside step mode must leave the clock parked.
    mode = 2'b01;
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (12) tick();
    tests_run += 2;
    if (cpu_clk !== 1'b0) begin tests_failed++; $display("[TB] FAIL step_ignored_clk got %b want 0", cpu_clk); end
    if (cycle_cnt !== CYC_WIDTH'(exp_cyc)) begin tests_failed++; $display("[TB] FAIL step_ignored_cycle got %0d want %0d", cycle_cnt, CYC_WIDTH'(exp_cyc)); end
  endtask

  task automatic test_rst_req();
    int hl, j;
    bit exp_clk, prev_clk, exp_nres;
    hl = cur_half + 1;
    mode = 2'b01;
    tests_run++;
    if (cpu_nreset !== 1'b1) begin tests_failed++; $display("[TB] FAIL rreq_pre_nreset got %b want 1", cpu_nreset); end
    prev_clk = 1'b0;
    cpu_rst_req = 1'b1;
    for (int k = 1; k <= 2 * RESET_CYCLES * hl + 6; k++) begin
      tick();
      cpu_rst_req = 1'b0;
      j = k - 1;
      exp_clk  = (j < 2 * RESET_CYCLES * hl) && phase_high(j, cur_half);
      exp_nres = !((k >= 2) && (k <= 2 * RESET_CYCLES * hl + 1));
      if (k == 1) exp_cyc = 0;
      else if (exp_clk && !prev_clk) exp_cyc++;
      tests_run += 3;
      if (cpu_clk !== exp_clk) begin tests_failed++; $display("[TB] FAIL rreq_clk k=%0d got %b want %b", k, cpu_clk, exp_clk); end
      if (cpu_nreset !== exp_nres) begin tests_failed++; $display("[TB] FAIL rreq_nreset k=%0d got %b want %b", k, cpu_nreset, exp_nres); end
      if (cycle_cnt !== CYC_WIDTH'(exp_cyc)) begin tests_failed++; $display("[TB] FAIL rreq_cycle k=%0d got %0d want %0d", k, cycle_cnt, CYC_WIDTH'(exp_cyc)); end
      prev_clk = exp_clk;
    end
  endtask

  task automatic test_async_reset();
    bit exp_clk, prev_clk;
    load_half(5);
    mode = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      tick();
      tests_run++;
      if (cpu_clk !== phase_high(k, 5)) begin tests_failed++; $display("[TB] FAIL ares_pre_clk k=%0d got %b want %b", k, cpu_clk, phase_high(k, 5)); end
    end
    #2 reset = 1'b1;
    #1;
    tests_run += 3;
    if (cpu_clk !== 1'b0) begin tests_failed++; $display("[TB] FAIL ares_clk got %b want 0", cpu_clk); end
    if (cpu_nreset !== 1'b0) begin tests_failed++; $display("[TB] FAIL ares_nreset got %b want 0", cpu_nreset); end
    if (cycle_cnt !== '0) begin tests_failed++; $display("[TB] FAIL ares_cycle got %0d want 0", cycle_cnt); end
    @(negedge mclk);
    reset = 1'b0;
    exp_cyc = 0;
    prev_clk = 1'b0;
    for (int k = 1; k <= 27; k++) begin
      tick();
      exp_clk = phase_high(k, DEFAULT_HALF);
      if (exp_clk && !prev_clk) exp_cyc++;
      tests_run += 3;
      if (cpu_clk !== exp_clk) begin tests_failed++; $display("[TB] FAIL ares_post_clk k=%0d got %b want %b", k, cpu_clk, exp_clk); end
      if (cpu_nreset !== (k >= 17)) begin tests_failed++; $display("[TB] FAIL ares_post_nreset k=%0d got %b", k, cpu_nreset); end
      if (cycle_cnt !== CYC_WIDTH'(exp_cyc)) begin tests_failed++; $display("[TB] FAIL ares_post_cycle k=%0d got %0d want %0d", k, cycle_cnt, CYC_WIDTH'(exp_cyc)); end
      prev_clk = exp_clk;
    end
  endtask

  // Continues at edge 28 of the post-reset run, which is a rising toggle.
  task automatic test_rst_req_on_rise();
    cpu_rst_req = 1'b1;
    for (int k = 28; k <= 41; k++) begin
      tick();
      cpu_rst_req = 1'b0;
      if (k == 28) begin
        tests_run += 2;
        if (cpu_clk !== 1'b1) begin tests_failed++; $display("[TB] FAIL rise_clr_clk got %b want 1", cpu_clk); end
        if (cycle_cnt !== '0) begin tests_failed++; $display("[TB] FAIL rise_clr_cycle got %0d want 0", cycle_cnt); end
      end
      if (k == 29 || k == 40 || k == 41) begin
        tests_run++;
        if (cpu_nreset !== (k == 41)) begin tests_failed++; $display("[TB] FAIL rise_clr_nreset k=%0d got %b want %b", k, cpu_nreset, k == 41); end
      end
      if (k == 30) begin
        tests_run++;
        if (cpu_clk !== 1'b1) begin tests_failed++; $display("[TB] FAIL rise_clr_phase got %b want 1", cpu_clk); end
      end
      if (k == 36) begin
        tests_run++;
        if (cycle_cnt !== CYC_WIDTH'(1)) begin tests_failed++; $display("[TB] FAIL rise_clr_recount got %0d want 1", cycle_cnt); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_halt();
    test_load_midphase();
    test_random_run();
    test_step();
    test_rst_req();
    test_async_reset();
    test_rst_req_on_rise();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
